// File: rtl/zprize_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier among NREQ requesters.
// Credits reserve response-FIFO space at issue time, so a return can always be queued.
module zprize_mul_sched #(
    parameter int NREQ = 4,
    parameter int W0   = 48,
    parameter int W1   = 48,
    parameter int LAT  = 6,
    parameter int FD   = 4,
    parameter int TW   = 8,
    parameter int IDW  = $clog2(NREQ),
    parameter int M    = 1 + IDW + TW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W0-1:0]        req_a,
    input  logic [NREQ*W1-1:0]        req_b,
    input  logic [NREQ*TW-1:0]        req_tag,
    output logic [W0-1:0]             mul_in0,
    output logic [W1-1:0]             mul_in1,
    output logic [M-1:0]              mul_m_i,
    input  logic [M-1:0]              mul_m_o,
    input  logic [W0+W1-1:0]          mul_out0,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [NREQ*(W0+W1)-1:0]   rsp_data,
    output logic [NREQ*TW-1:0]        rsp_tag,
    output logic                      idle
);
    localparam int DW  = W0 + W1;
    localparam int EW  = DW + TW;
    localparam int PW  = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW  = $clog2(FD + 1);
    localparam int DRW = $clog2(LAT + 2);

    logic [CW-1:0]   credit_q [NREQ];
    logic [CW-1:0]   credit_d [NREQ];
    logic [CW-1:0]   cnt_q    [NREQ];
    logic [CW-1:0]   cnt_d    [NREQ];
    logic [PW-1:0]   wp_q     [NREQ];
    logic [PW-1:0]   wp_d     [NREQ];
    logic [PW-1:0]   rp_q     [NREQ];
    logic [PW-1:0]   rp_d     [NREQ];
    logic [EW-1:0]   mem_q    [NREQ][FD];
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [NREQ-1:0] elig, grant, push, pop;
    logic [DRW-1:0]  drain_q;
    logic            drained;
    logic [M-1:0]    mul_m_q;
    logic [W0-1:0]   a_q;
    logic [W1-1:0]   b_q;
    logic            ret_vld;
    logic [IDW-1:0]  ret_id;
    logic [TW-1:0]   ret_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign drained   = (drain_q == '0);
    assign req_ready = grant;
    assign mul_in0   = a_q;
    assign mul_in1   = b_q;
    assign mul_m_i   = mul_m_q;
    assign ret_vld   = rst & drained & mul_m_o[M-1];
    assign ret_id    = mul_m_o[TW +: IDW];
    assign ret_tag   = mul_m_o[TW-1:0];

    always_comb begin
        grant   = '0;
        gnt_idx = rr_q;
        gnt_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = rst & drained & req_valid[i] & (credit_q[i] != '0);
        end
        // Search starts just after the last winner so every requester gets a turn.
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_any && elig[(int'(rr_q) + k) % NREQ]) begin
                gnt_idx = IDW'((int'(rr_q) + k) % NREQ);
                grant[(int'(rr_q) + k) % NREQ] = 1'b1;
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        idle = rst & drained;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i]            = rst & (cnt_q[i] != '0);
            rsp_data[i*DW +: DW]    = mem_q[i][rp_q[i]][EW-1:TW];
            rsp_tag[i*TW +: TW]     = mem_q[i][rp_q[i]][TW-1:0];
            if (credit_q[i] != CW'(FD)) idle = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            push[i]     = ret_vld && (ret_id == IDW'(i));
            pop[i]      = rsp_valid[i] & rsp_ready[i];
            credit_d[i] = credit_q[i];
            cnt_d[i]    = cnt_q[i];
            wp_d[i]     = push[i] ? ptr_inc(wp_q[i]) : wp_q[i];
            rp_d[i]     = pop[i] ? ptr_inc(rp_q[i]) : rp_q[i];
            if (grant[i] && !pop[i]) credit_d[i] = credit_q[i] - CW'(1);
            else if (!grant[i] && pop[i]) credit_d[i] = credit_q[i] + CW'(1);
            if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + CW'(1);
            else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CW'(1);
        end
    end

    // Issue stage / control state; the external multiplier is not reset, hence the drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q    <= IDW'(NREQ - 1);
            mul_m_q <= '0;
            drain_q <= DRW'(LAT + 1);
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= CW'(FD);
                cnt_q[i]    <= '0;
                wp_q[i]     <= '0;
                rp_q[i]     <= '0;
            end
        end else begin
            if (gnt_any) begin
                rr_q    <= gnt_idx;
                mul_m_q <= {1'b1, gnt_idx, req_tag[int'(gnt_idx)*TW +: TW]};
            end else begin
                mul_m_q[M-1] <= 1'b0;
            end
            if (!drained) drain_q <= drain_q - DRW'(1);
            for (int i = 0; i < NREQ; i++) begin
                assert (!(push[i] && cnt_q[i] == CW'(FD)));
                credit_q[i] <= credit_d[i];
                cnt_q[i]    <= cnt_d[i];
                wp_q[i]     <= wp_d[i];
                rp_q[i]     <= rp_d[i];
            end
        end
    end

    // Operand and FIFO storage hold data only, no reset needed.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            a_q <= req_a[int'(gnt_idx)*W0 +: W0];
            b_q <= req_b[int'(gnt_idx)*W1 +: W1];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) mem_q[i][wp_q[i]] <= {mul_out0, ret_tag};
        end
    end
endmodule

// File: doc/zprize_mul_sched.md
ZPRIZE_MUL_SCHED -- requirements
Module: zprize_mul_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NREQ, 4: number of requesters.
- W0, 48: operand A width.
- W1, 48: operand B width.
- LAT, 6: fixed multiplier latency, mul_m_i to mul_m_o and mul_in* to mul_out0.
- FD, 4: per-requester response FIFO depth.
- TW, 8: user tag width.
- IDW, $clog2(NREQ): requester ID width.
- M, 1+IDW+TW: metadata width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous and active-low.
- req_valid, in, NREQ: operand pair offered, one bit per requester.
- req_ready, out, NREQ: request accepted this cycle.
- req_a, in, NREQ*W0: operand A per requester, packed by index.
- req_b, in, NREQ*W1: operand B per requester, packed by index.
- req_tag, in, NREQ*TW: user tag per requester.
- mul_in0, out, W0: multiplier operand A.
- mul_in1, out, W1: multiplier operand B.
- mul_m_i, out, M: metadata into multiplier, {valid, id, tag}.
- mul_m_o, in, M: metadata out of multiplier.
- mul_out0, in, W0+W1: product.
- rsp_valid, out, NREQ: response available.
- rsp_ready, in, NREQ: response consumed.
- rsp_data, out, NREQ*(W0+W1): product per requester.
- rsp_tag, out, NREQ*TW: returned tag per requester.
- idle, out, 1: no accepted work outstanding.

Function
REQ-003 Eligibility: requester i SHALL be eligible when req_valid[i]=1, credit[i]>0 and the drain counter is 0.
REQ-004 Arbitration: round-robin, at most one grant per cycle, searching from rr_ptr+1 upward with wrap at NREQ-1 to 0; rr_ptr SHALL update to the granted index on grant and hold otherwise.
REQ-005 req_ready SHALL be a combinational one-hot (or zero) grant; acceptance = req_valid[i] & req_ready[i].
REQ-006 On acceptance, mul_in0, mul_in1 and mul_m_i={1,i,tag} SHALL be registered the next cycle; with no acceptance, mul_m_i valid bit SHALL be 0 and the operands SHALL hold their values.
REQ-007 credit[i] SHALL start at FD, decrement on acceptance and increment on a response pop; simultaneous accept and pop SHALL leave it unchanged; credit SHALL never exceed FD or go below 0.
REQ-008 A return with mul_m_o valid bit = 1 SHALL push {mul_out0, tag} into FIFO[id] on that clock edge.
REQ-009 Per-requester FIFOs SHALL be show-ahead: rsp_valid[i] = not empty; pop = rsp_valid[i] & rsp_ready[i]; a pushed entry SHALL become visible on the following cycle.
REQ-010 Simultaneous push and pop SHALL keep the occupancy constant; a push to a full FIFO is unreachable by construction (credits) and SHALL be flagged by an assertion.
REQ-011 Latency from acceptance at edge t to rsp_valid, with an empty FIFO, SHALL be exactly LAT+2 cycles.
REQ-012 Per-requester responses SHALL return in acceptance order; interleaving across requesters SHALL follow issue order.
REQ-013 A stalled requester (rsp_ready=0) SHALL block only itself once its credit reaches 0; other requesters continue at full rate.
REQ-014 Throughput: sustained one acceptance per cycle while any requester is eligible.
REQ-015 idle SHALL equal (all credit==FD) & (drain counter==0).

Reset
REQ-016 While rst=0: credits = FD, FIFOs empty, rr_ptr = NREQ-1, mul_m_i = 0, req_ready = 0, rsp_valid = 0, idle = 0.
REQ-017 The multiplier pipeline is not reset, so on rst deassertion a drain counter SHALL be loaded with LAT+1 and decrement to 0; during the drain, all mul_m_o returns SHALL be discarded and no grants issued.
REQ-018 A reset asserted mid-operation SHALL drop all in-flight and queued results with no spurious rsp_valid afterwards.

Verification
REQ-019 Single requester: req0 a=3, b=5, tag=0x11 after drain -> rsp_valid[0] exactly LAT+2 cycles later with data 15, tag 0x11.
REQ-020 All four requesters valid continuously with rsp_ready=all ones -> grants 0,1,2,3,0,... with one per cycle; every product correct; idle=1 after the final pop.
REQ-021 rsp_ready[2]=0 held -> exactly FD acceptances for requester 2, then req_ready[2]=0 while others keep full rate; releasing rsp_ready[2] restores grants one cycle after the pop.
REQ-022 Max operands a=2^48-1, b=2^48-1 -> data = 2^96 - 2^49 + 1.
REQ-023 Reset pulsed with 3 results in flight -> no rsp_valid within the following 2*LAT cycles; first grant occurs LAT+1 cycles after reset release.
REQ-024 Pop and push on FIFO[1] in the same cycle at occupancy 1 -> occupancy stays 1 and data order is preserved.
